// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hold/flush sequencer for the IF/ID, ID/EX, EX/MEM and
// MEM/WB pipeline registers. Handles post-reset warm-up, load-use bubbles,
// taken branch/jump squashes and multi-cycle data-memory waits with a timeout.
// All state updates on the falling clk edge, the same edge as the pipe.
// Optional build macro: HAZARD_PERF_CNT_EN enables the stall_cycles counter;
// without it stall_cycles is tied to zero.
// Memory handshake: an access is outstanding while mem_req_MEM=1 and
// mem_ack=0; the edge that sees mem_ack=1 completes it and lets the pipe advance.
module pipe_hazard_ctrl #(
    parameter int WARMUP_CYCLES = 4,
    parameter int MEM_TIMEOUT   = 15,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        async_rst,
    input  logic        clr_err,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        memread_EX,
    input  logic [4:0]  rt_EX,
    input  logic        branch_taken_EX,
    input  logic        jump_ID,
    input  logic        mem_req_MEM,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush_n,
    output logic        idex_flush_n,
    output logic        exmem_flush_n,
    output logic        memwb_flush_n,
    output logic        mem_timeout_err,
    output logic [15:0] stall_cycles,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        S_FLUSH    = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q;
    logic             load_use;
    logic             mem_stall;

    assign state_dbg_o     = state_q;
    assign mem_timeout_err = err_q;
    assign cnt_inc         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign load_use        = memread_EX && (rt_EX != 5'd0) &&
                             ((rt_EX == rs_ID) || (rt_EX == rt_ID));

    // State, counter and error flag register on the pipe's falling edge.
    always_ff @(negedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state_q <= S_FLUSH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= (state_d == S_ERROR);
        end
    end

    // Next state and combinational hold/flush strobes; reset forces all low.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_stall     = 1'b0;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        ifid_flush_n  = 1'b1;
        idex_flush_n  = 1'b1;
        exmem_flush_n = 1'b1;
        memwb_flush_n = 1'b1;
        case (state_q)
            S_FLUSH: begin
                pc_en         = 1'b0;
                ifid_flush_n  = 1'b0;
                idex_flush_n  = 1'b0;
                exmem_flush_n = 1'b0;
                memwb_flush_n = 1'b0;
                if (cnt_q == WARM_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RUN, S_MEM_WAIT: begin
                // In MEM_WAIT the ack alone decides; in RUN a new request must be pending.
                if (state_q == S_MEM_WAIT) mem_stall = !mem_ack;
                else                       mem_stall = mem_req_MEM && !mem_ack;
                if (mem_stall) begin
                    pc_en         = 1'b0;
                    ifid_en       = 1'b0;
                    idex_en       = 1'b0;
                    exmem_en      = 1'b0;
                    memwb_flush_n = 1'b0;
                end else if (branch_taken_EX) begin
                    ifid_flush_n = 1'b0;
                    idex_flush_n = 1'b0;
                end else if (load_use) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_flush_n = 1'b0;
                end else if (jump_ID) begin
                    ifid_flush_n = 1'b0;
                end
                if (state_q == S_RUN) begin
                    if (mem_stall) begin
                        state_d = S_MEM_WAIT;
                        cnt_d   = '0;
                    end
                end else if (mem_ack) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ERROR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ERROR: begin
                pc_en         = 1'b0;
                ifid_en       = 1'b0;
                idex_en       = 1'b0;
                exmem_en      = 1'b0;
                ifid_flush_n  = 1'b0;
                idex_flush_n  = 1'b0;
                exmem_flush_n = 1'b0;
                memwb_flush_n = 1'b0;
                if (clr_err) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_FLUSH;
                cnt_d   = '0;
            end
        endcase
        if (!async_rst) begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            idex_en       = 1'b0;
            exmem_en      = 1'b0;
            ifid_flush_n  = 1'b0;
            idex_flush_n  = 1'b0;
            exmem_flush_n = 1'b0;
            memwb_flush_n = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q;
    assign stall_cycles = stall_q;

    // Saturating count of edges where the PC is held during RUN or MEM_WAIT.
    always_ff @(negedge clk or negedge async_rst) begin
        if (!async_rst) begin
            stall_q <= 16'h0000;
        end else if (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) &&
                     !pc_en && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule
